// File: rtl/alu_result_checker_if.sv
// Transaction, verdict and statistics bundle shared by the ALU result checker and its driver.
// The master side drives operands and RESULT; the slave side is the checker itself.
interface alu_result_checker_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             CLEAR;
  logic             VALID;
  logic             READY;
  logic [WIDTH-1:0] DATA1;
  logic [WIDTH-1:0] DATA2;
  logic [2:0]       SELECT;
  logic [WIDTH-1:0] RESULT;
  logic             DONE;
  logic             PASS;
  logic             RSVD;
  logic             ERROR;
  logic [CNT_W-1:0] PASS_COUNT;
  logic [CNT_W-1:0] FAIL_COUNT;
  logic [WIDTH-1:0] FAIL_DATA1;
  logic [WIDTH-1:0] FAIL_DATA2;
  logic [WIDTH-1:0] FAIL_RESULT;
  logic [WIDTH-1:0] FAIL_EXPECTED;
  logic [2:0]       FAIL_SELECT;

  modport master (
    output CLEAR, VALID, DATA1, DATA2, SELECT, RESULT,
    input  READY, DONE, PASS, RSVD, ERROR, PASS_COUNT, FAIL_COUNT,
    input  FAIL_DATA1, FAIL_DATA2, FAIL_RESULT, FAIL_EXPECTED, FAIL_SELECT
  );

  modport slave (
    input  CLEAR, VALID, DATA1, DATA2, SELECT, RESULT,
    output READY, DONE, PASS, RSVD, ERROR, PASS_COUNT, FAIL_COUNT,
    output FAIL_DATA1, FAIL_DATA2, FAIL_RESULT, FAIL_EXPECTED, FAIL_SELECT
  );
endinterface

// File: rtl/alu_result_checker.sv
// Checks one ALU transaction at a time: captures operands, waits SETTLE_CYCLES, samples RESULT,
// compares with a locally computed value and keeps saturating statistics plus a first-failure capture.
module alu_result_checker #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input logic                CLK,
  input logic                RESET,
  alu_result_checker_if.slave bus
);

  localparam int CW = $clog2(SETTLE_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, REPORT} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d1_q, d1_d, d2_q, d2_d, res_q, res_d;
  logic [2:0]       sel_q, sel_d;
  logic             unstable_q, unstable_d;
  logic             pass_q, pass_d, rsvd_q, rsvd_d, error_q, error_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, fcnt_q, fcnt_d;
  logic [WIDTH-1:0] fd1_q, fd1_d, fd2_q, fd2_d, fres_q, fres_d, fexp_q, fexp_d;
  logic [2:0]       fsel_q, fsel_d;
  logic [WIDTH-1:0] expected;
  logic             reserved, fail;

  always_comb begin
    expected = '0;
    case (sel_q[1:0])
      2'b00:   expected = d2_q;
      2'b01:   expected = d1_q + d2_q;
      2'b10:   expected = d1_q & d2_q;
      default: expected = d1_q | d2_q;
    endcase
  end

  assign reserved = sel_q[2];
  assign fail     = !reserved && (unstable_q || (res_q != expected));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    sel_d      = sel_q;
    res_d      = res_q;
    unstable_d = unstable_q;
    pass_d     = pass_q;
    rsvd_d     = rsvd_q;
    error_d    = error_q;
    pcnt_d     = pcnt_q;
    fcnt_d     = fcnt_q;
    fd1_d      = fd1_q;
    fd2_d      = fd2_q;
    fres_d     = fres_q;
    fexp_d     = fexp_q;
    fsel_d     = fsel_q;
    if (bus.CLEAR) begin
      state_d    = IDLE;
      unstable_d = 1'b0;
      pass_d     = 1'b0;
      rsvd_d     = 1'b0;
      error_d    = 1'b0;
      pcnt_d     = '0;
      fcnt_d     = '0;
      fd1_d      = '0;
      fd2_d      = '0;
      fres_d     = '0;
      fexp_d     = '0;
      fsel_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.VALID) begin
            d1_d       = bus.DATA1;
            d2_d       = bus.DATA2;
            sel_d      = bus.SELECT;
            cnt_d      = CW'(SETTLE_CYCLES);
            unstable_d = 1'b0;
            state_d    = SETTLE;
          end
        end
        SETTLE: begin
          // Operands must stay put while the ALU settles, otherwise RESULT is meaningless.
          if (bus.DATA1 != d1_q || bus.DATA2 != d2_q || bus.SELECT != sel_q) unstable_d = 1'b1;
          if (cnt_q == '0) begin
            res_d   = bus.RESULT;
            state_d = CHECK;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        CHECK: begin
          pass_d  = !fail && !reserved;
          rsvd_d  = reserved;
          state_d = REPORT;
          if (fail) begin
            error_d = 1'b1;
            if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
            if (fcnt_q == '0 && !error_q) begin
              fd1_d  = d1_q;
              fd2_d  = d2_q;
              fres_d = res_q;
              fexp_d = expected;
              fsel_d = sel_q;
            end
          end else if (!reserved) begin
            if (pcnt_q != '1) pcnt_d = pcnt_q + 1'b1;
          end
        end
        REPORT:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      sel_q      <= '0;
      res_q      <= '0;
      unstable_q <= 1'b0;
      pass_q     <= 1'b0;
      rsvd_q     <= 1'b0;
      error_q    <= 1'b0;
      pcnt_q     <= '0;
      fcnt_q     <= '0;
      fd1_q      <= '0;
      fd2_q      <= '0;
      fres_q     <= '0;
      fexp_q     <= '0;
      fsel_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      sel_q      <= sel_d;
      res_q      <= res_d;
      unstable_q <= unstable_d;
      pass_q     <= pass_d;
      rsvd_q     <= rsvd_d;
      error_q    <= error_d;
      pcnt_q     <= pcnt_d;
      fcnt_q     <= fcnt_d;
      fd1_q      <= fd1_d;
      fd2_q      <= fd2_d;
      fres_q     <= fres_d;
      fexp_q     <= fexp_d;
      fsel_q     <= fsel_d;
    end
  end

  assign bus.READY         = (state_q == IDLE);
  assign bus.DONE          = (state_q == REPORT);
  assign bus.PASS          = pass_q;
  assign bus.RSVD          = rsvd_q;
  assign bus.ERROR         = error_q;
  assign bus.PASS_COUNT    = pcnt_q;
  assign bus.FAIL_COUNT    = fcnt_q;
  assign bus.FAIL_DATA1    = fd1_q;
  assign bus.FAIL_DATA2    = fd2_q;
  assign bus.FAIL_RESULT   = fres_q;
  assign bus.FAIL_EXPECTED = fexp_q;
  assign bus.FAIL_SELECT   = fsel_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: a default instance (SETTLE_CYCLES=2, CNT_W=16)
// and a narrow instance (SETTLE_CYCLES=0, CNT_W=2) for saturation and back-to-back throughput.
module tb_alu_result_checker;

  logic CLK = 1'b0;
  logic RESET;
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;

  alu_result_checker_if #(.WIDTH(8), .CNT_W(16)) bus ();
  alu_result_checker_if #(.WIDTH(8), .CNT_W(2))  bus2 ();

  alu_result_checker #(.WIDTH(8), .SETTLE_CYCLES(2), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus.slave)
  );
  alu_result_checker #(.WIDTH(8), .SETTLE_CYCLES(0), .CNT_W(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .bus(bus2.slave)
  );

  // Issue one transaction on the default instance and return edges from accept to DONE.
  task automatic run_txn(input logic [2:0] sel, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] res, input bit glitch, output int lat);
    int guard = 0;
    @(negedge CLK);
    while (!bus.READY && guard < 20) begin @(negedge CLK); guard++; end
    bus.SELECT = sel; bus.DATA1 = d1; bus.DATA2 = d2; bus.RESULT = res; bus.VALID = 1'b1;
    @(posedge CLK); #1 bus.VALID = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge CLK); #1; lat++;
      if (glitch && lat == 1) bus.DATA2 = 8'h3A;
      if (bus.DONE) break;
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.READY !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", bus.READY); end
    checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", bus.DONE); end
    checks++; if ({bus.PASS, bus.RSVD, bus.ERROR} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {bus.PASS, bus.RSVD, bus.ERROR}); end
    checks++; if ({bus.PASS_COUNT, bus.FAIL_COUNT} !== 32'h0) begin errors++; $display("FAIL rst_counts got=%h exp=0", {bus.PASS_COUNT, bus.FAIL_COUNT}); end
    checks++; if ({bus.FAIL_DATA1, bus.FAIL_DATA2, bus.FAIL_RESULT, bus.FAIL_EXPECTED, bus.FAIL_SELECT} !== 35'h0) begin
      errors++; $display("FAIL rst_capture got=%h exp=0", {bus.FAIL_DATA1, bus.FAIL_DATA2, bus.FAIL_RESULT, bus.FAIL_EXPECTED, bus.FAIL_SELECT}); end
  endtask

  task automatic test_add_pass();
    int lat;
    run_txn(3'b001, 8'hFF, 8'h01, 8'h00, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency got=%0d exp=4", lat); end
    checks++; if ({bus.PASS, bus.RSVD} !== 2'b10) begin errors++; $display("FAIL add_pass got=%b exp=10", {bus.PASS, bus.RSVD}); end
    checks++; if (bus.PASS_COUNT !== 16'd1) begin errors++; $display("FAIL add_pcount got=%0d exp=1", bus.PASS_COUNT); end
    checks++; if (bus.ERROR !== 1'b0) begin errors++; $display("FAIL add_error got=%b exp=0", bus.ERROR); end
    @(posedge CLK); #1;
    checks++; if ({bus.DONE, bus.READY, bus.PASS} !== 3'b011) begin errors++; $display("FAIL add_after got=%b exp=011", {bus.DONE, bus.READY, bus.PASS}); end
  endtask

  task automatic test_fail_capture();
    int lat;
    run_txn(3'b010, 8'h32, 8'h3A, 8'h3A, 1'b0, lat);
    checks++; if ({bus.PASS, bus.ERROR} !== 2'b01) begin errors++; $display("FAIL and_verdict got=%b exp=01", {bus.PASS, bus.ERROR}); end
    checks++; if (bus.FAIL_COUNT !== 16'd1) begin errors++; $display("FAIL and_fcount got=%0d exp=1", bus.FAIL_COUNT); end
    checks++; if ({bus.FAIL_EXPECTED, bus.FAIL_RESULT} !== 16'h323A) begin errors++; $display("FAIL and_capture got=%h exp=323a", {bus.FAIL_EXPECTED, bus.FAIL_RESULT}); end
    checks++; if ({bus.FAIL_DATA1, bus.FAIL_DATA2, bus.FAIL_SELECT} !== {8'h32, 8'h3A, 3'b010}) begin
      errors++; $display("FAIL and_ops got=%h exp=%h", {bus.FAIL_DATA1, bus.FAIL_DATA2, bus.FAIL_SELECT}, {8'h32, 8'h3A, 3'b010}); end
    run_txn(3'b011, 8'h32, 8'h3A, 8'h00, 1'b0, lat);
    checks++; if (bus.FAIL_COUNT !== 16'd2) begin errors++; $display("FAIL or_fcount got=%0d exp=2", bus.FAIL_COUNT); end
    checks++; if ({bus.FAIL_EXPECTED, bus.FAIL_RESULT, bus.FAIL_SELECT} !== {8'h32, 8'h3A, 3'b010}) begin
      errors++; $display("FAIL or_capture_held got=%h exp=%h", {bus.FAIL_EXPECTED, bus.FAIL_RESULT, bus.FAIL_SELECT}, {8'h32, 8'h3A, 3'b010}); end
    checks++; if (bus.PASS_COUNT !== 16'd1) begin errors++; $display("FAIL or_pcount got=%0d exp=1", bus.PASS_COUNT); end
  endtask

  task automatic test_reserved();
    int lat;
    run_txn(3'b101, 8'h12, 8'h34, 8'h99, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rsvd_latency got=%0d exp=4", lat); end
    checks++; if ({bus.RSVD, bus.PASS} !== 2'b10) begin errors++; $display("FAIL rsvd_flags got=%b exp=10", {bus.RSVD, bus.PASS}); end
    checks++; if ({bus.PASS_COUNT, bus.FAIL_COUNT} !== {16'd1, 16'd2}) begin errors++; $display("FAIL rsvd_counts got=%h exp=00010002", {bus.PASS_COUNT, bus.FAIL_COUNT}); end
  endtask

  task automatic test_clear_idle();
    @(negedge CLK);
    bus.CLEAR = 1'b1; bus.VALID = 1'b1; bus.SELECT = 3'b001; bus.DATA1 = 8'h01; bus.DATA2 = 8'h02; bus.RESULT = 8'h03;
    @(posedge CLK); #1 bus.CLEAR = 1'b0; bus.VALID = 1'b0;
    checks++; if (bus.READY !== 1'b1) begin errors++; $display("FAIL clr_idle_ready got=%b exp=1", bus.READY); end
    checks++; if ({bus.ERROR, bus.PASS, bus.RSVD, bus.PASS_COUNT, bus.FAIL_COUNT, bus.FAIL_EXPECTED} !== 43'h0) begin
      errors++; $display("FAIL clr_idle_state got=%h exp=0", {bus.ERROR, bus.PASS, bus.RSVD, bus.PASS_COUNT, bus.FAIL_COUNT, bus.FAIL_EXPECTED}); end
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin @(posedge CLK); #1; if (bus.DONE) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL clr_valid_nodone got=%0d exp=0", seen); end
    end
  endtask

  task automatic test_unstable();
    int lat;
    run_txn(3'b000, 8'h55, 8'hC6, 8'hC6, 1'b1, lat);
    checks++; if ({bus.PASS, bus.ERROR, bus.FAIL_COUNT} !== {2'b01, 16'd1}) begin
      errors++; $display("FAIL unst_verdict got=%h exp=%h", {bus.PASS, bus.ERROR, bus.FAIL_COUNT}, {2'b01, 16'd1}); end
    checks++; if ({bus.FAIL_DATA2, bus.FAIL_EXPECTED, bus.FAIL_RESULT} !== 24'hC6C6C6) begin
      errors++; $display("FAIL unst_capture got=%h exp=c6c6c6", {bus.FAIL_DATA2, bus.FAIL_EXPECTED, bus.FAIL_RESULT}); end
  endtask

  task automatic test_clear_settle();
    int seen = 0;
    @(negedge CLK);
    bus.SELECT = 3'b001; bus.DATA1 = 8'h10; bus.DATA2 = 8'h20; bus.RESULT = 8'h30; bus.VALID = 1'b1;
    @(posedge CLK); #1 bus.VALID = 1'b0;
    @(negedge CLK); bus.CLEAR = 1'b1;
    @(posedge CLK); #1 bus.CLEAR = 1'b0;
    checks++; if ({bus.READY, bus.DONE} !== 2'b10) begin errors++; $display("FAIL clr_settle_ready got=%b exp=10", {bus.READY, bus.DONE}); end
    checks++; if ({bus.ERROR, bus.PASS_COUNT, bus.FAIL_COUNT, bus.FAIL_DATA2} !== 41'h0) begin
      errors++; $display("FAIL clr_settle_state got=%h exp=0", {bus.ERROR, bus.PASS_COUNT, bus.FAIL_COUNT, bus.FAIL_DATA2}); end
    for (int i = 0; i < 6; i++) begin @(posedge CLK); #1; if (bus.DONE) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL clr_settle_nodone got=%0d exp=0", seen); end
  endtask

  task automatic test_reset_midflight();
    int lat;
    run_txn(3'b010, 8'h32, 8'h3A, 8'h00, 1'b0, lat);
    checks++; if ({bus.ERROR, bus.FAIL_COUNT} !== {1'b1, 16'd1}) begin errors++; $display("FAIL pre_rst_fail got=%h exp=10001", {bus.ERROR, bus.FAIL_COUNT}); end
    @(negedge CLK); @(negedge CLK);
    bus.SELECT = 3'b001; bus.DATA1 = 8'h01; bus.DATA2 = 8'h01; bus.RESULT = 8'h02; bus.VALID = 1'b1;
    @(posedge CLK); #1 bus.VALID = 1'b0;
    @(posedge CLK); #2 RESET = 1'b0;
    #1;
    checks++; if ({bus.READY, bus.DONE, bus.PASS, bus.RSVD, bus.ERROR} !== 5'b10000) begin
      errors++; $display("FAIL midrst_flags got=%b exp=10000", {bus.READY, bus.DONE, bus.PASS, bus.RSVD, bus.ERROR}); end
    checks++; if ({bus.FAIL_COUNT, bus.FAIL_DATA1, bus.FAIL_EXPECTED, bus.FAIL_SELECT} !== 35'h0) begin
      errors++; $display("FAIL midrst_capture got=%h exp=0", {bus.FAIL_COUNT, bus.FAIL_DATA1, bus.FAIL_EXPECTED, bus.FAIL_SELECT}); end
    @(negedge CLK); RESET = 1'b1;
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int first = 0;
    int last = 0;
    int bad_gap = 0;
    @(negedge CLK); bus2.VALID = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge CLK); #1;
      if (bus2.DONE) begin
        if (dones == 0) first = e;
        else if (e - last != 4) bad_gap++;
        last = e; dones++;
      end
    end
    checks++; if (bus2.READY !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_done got=%b exp=1", bus2.READY); end
    @(negedge CLK); bus2.VALID = 1'b0;
    for (int e = 0; e < 6; e++) begin @(posedge CLK); #1; if (bus2.DONE) dones++; end
    checks++; if (first !== 3) begin errors++; $display("FAIL b2b_first_done got=%0d exp=3", first); end
    checks++; if (dones !== 5) begin errors++; $display("FAIL b2b_done_count got=%0d exp=5", dones); end
    checks++; if (bad_gap !== 0) begin errors++; $display("FAIL b2b_spacing got=%0d exp=0", bad_gap); end
    checks++; if ({bus2.PASS_COUNT, bus2.FAIL_COUNT, bus2.ERROR} !== 5'b11000) begin
      errors++; $display("FAIL sat_counts got=%b exp=11000", {bus2.PASS_COUNT, bus2.FAIL_COUNT, bus2.ERROR}); end
  endtask

  initial begin
    RESET = 1'b0;
    bus.CLEAR = 1'b0;  bus.VALID = 1'b0;  bus.SELECT = '0;  bus.DATA1 = '0;  bus.DATA2 = '0;  bus.RESULT = '0;
    bus2.CLEAR = 1'b0; bus2.VALID = 1'b0; bus2.SELECT = 3'b001; bus2.DATA1 = 8'h32; bus2.DATA2 = 8'h3A; bus2.RESULT = 8'h6C;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    #1;
    test_reset();
    test_add_pass();
    test_fail_capture();
    test_reserved();
    test_clear_idle();
    test_unstable();
    test_clear_settle();
    test_reset_midflight();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_result_checker.md
# alu_result_checker

Hardware response checker for the 8-bit ALU's stimulus interface. It accepts one operand/opcode transaction on a VALID/READY handshake and waits a programmable settle time for the ALU's delayed output. It then samples the ALU RESULT, compares it against a locally computed expected value, and keeps pass/fail statistics plus a first-failure capture. It sits beside the ALU in self-checking builds, fed by the same DATA1/DATA2/SELECT signals that drive the ALU.

## Interface
- WIDTH, 8: operand/result width.
- SETTLE_CYCLES, 2: extra cycles waited before RESULT is sampled (covers ALU propagation delay).
- CNT_W, 16: width of pass/fail counters.

- CLK  in  1  clock, all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- CLEAR  in  1  synchronous clear of statistics and FSM; priority over VALID.
- VALID  in  1  DATA1/DATA2/SELECT presented this cycle.
- READY  out  1  checker can accept a transaction (high only in IDLE).
- DATA1, DATA2  in  WIDTH  operands as applied to the ALU.
- SELECT  in  3  ALU opcode as applied to the ALU.
- RESULT  in  WIDTH  ALU output under check.
- DONE  out  1  one-cycle pulse: verdict valid.
- PASS  out  1  verdict of last check; valid while DONE high.
- RSVD  out  1  last SELECT was reserved (1xx); valid while DONE high.
- ERROR  out  1  sticky: at least one failure since reset/CLEAR.
- PASS_COUNT, FAIL_COUNT  out  CNT_W  saturating counters.
- FAIL_DATA1, FAIL_DATA2, FAIL_RESULT, FAIL_EXPECTED  out  WIDTH  first-failure capture.
- FAIL_SELECT  out  3  first-failure opcode.

## Operation
- Expected value from captured operands: 000 -> DATA2; 001 -> (DATA1+DATA2) mod 2^WIDTH, carry discarded; 010 -> DATA1 & DATA2; 011 -> DATA1 | DATA2; 1xx -> reserved, not compared.
- FSM states: IDLE, SETTLE, CHECK, REPORT.
  - IDLE: READY=1. VALID=1 at an edge captures DATA1/DATA2/SELECT, loads settle counter with SETTLE_CYCLES, -> SETTLE.
  - SETTLE: each edge, if counter==0 sample RESULT, -> CHECK; else decrement. Every cycle compare live DATA1/DATA2/SELECT with captured values; any difference sets internal unstable flag.
  - CHECK: fail = !reserved & (unstable | sampled RESULT != expected). At exit edge: pass -> PASS_COUNT++, fail -> FAIL_COUNT++ and ERROR=1, reserved -> no counter change. -> REPORT.
  - REPORT: DONE=1, PASS=!fail & !reserved, RSVD=reserved; -> IDLE next edge.
- VALID outside IDLE is ignored (not queued).
- First-failure capture loads only when FAIL_COUNT was 0 and ERROR was 0 before the failing check; later failures never overwrite it. On an unstable fail, capture holds the captured operands and expected value, plus the sampled RESULT.
- Counters saturate at 2^CNT_W-1; no wrap.
- CLEAR (any state): counters, ERROR, captures, unstable flag -> 0; FSM -> IDLE; in-flight transaction discarded, no DONE.

## Timing
- Reset (RESET low, asynchronous): FSM=IDLE, READY=1, DONE=0, PASS=0, RSVD=0, ERROR=0, counters=0, all FAIL_* =0. RESET low mid-transaction aborts it immediately.
- Accept edge = edge k with READY & VALID. RESULT sampled at edge k+SETTLE_CYCLES+1. Counters/ERROR/captures update at edge k+SETTLE_CYCLES+2. DONE is high during cycle after that edge, low after edge k+SETTLE_CYCLES+3.
- PASS/RSVD hold their value until next REPORT (or reset/CLEAR -> 0).
- READY re-asserts the cycle after DONE. Max throughput: one check per SETTLE_CYCLES+4 cycles.
- SETTLE_CYCLES=0 is legal: SETTLE lasts one cycle.
- CLEAR and VALID at the same edge in IDLE: CLEAR wins, nothing captured.

## Test plan
- Reset, SETTLE_CYCLES=2. Apply SELECT=001, DATA1=0xFF, DATA2=0x01, RESULT=0x00, VALID one cycle -> DONE high 4 edges after accept; PASS=1, PASS_COUNT=1, ERROR=0.
- SELECT=010, DATA1=0x32, DATA2=0x3A, RESULT=0x3A -> PASS=0, ERROR=1, FAIL_COUNT=1, FAIL_EXPECTED=0x32, FAIL_RESULT=0x3A. A second failing check (SELECT=011, 0x32|0x3A, RESULT=0x00) -> FAIL_COUNT=2, capture unchanged.
- SELECT=101, any RESULT -> DONE with RSVD=1, PASS=0, both counters unchanged.
- SELECT=000, DATA2=0xC6, RESULT=0xC6, DATA2 changed to 0x3A mid-SETTLE -> fail counted; FAIL_DATA2=0xC6, FAIL_EXPECTED=0xC6.
- CLEAR asserted during SETTLE -> no DONE; counters/ERROR=0, READY=1 next cycle. RESET pulsed low mid-SETTLE -> all outputs at reset values immediately.
- CNT_W=2: five consecutive passing ADD checks (0x32+0x3A, RESULT=0x6C) -> PASS_COUNT=3 (saturated); VALID held high across REPORT accepted only in IDLE.
